psr_condition_unit: RTL and testbench
=====================================

Name: psr_condition_unit

Overview:
- Consumer end of the ALU flag interface. Captures the ALU Z/N/C/V outputs into a program status register (PSR) when the EX-stage instruction has its S bit set.
- Evaluates the 4-bit condition field of the ID-stage instruction against the current flags, with forwarding from EX.
- Resolves conditional branches and branch-with-link, and generates a one-cycle IF flush after a taken branch.
- Also supplies the registered carry flag back to the ALU for add-with-carry and subtract-with-carry.

Parameters:
- FLAG_RST, 4'b0000: reset value of the PSR flags, ordered {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- alu_n  input  1  ALU negative flag (EX)
- alu_z  input  1  ALU zero flag (EX)
- alu_c  input  1  ALU carry flag (EX)
- alu_v  input  1  ALU overflow flag (EX)
- s_bit_ex  input  1  EX instruction updates flags
- stall  input  1  pipeline hold; freezes all state
- cond_id  input  4  condition field of the ID instruction
- branch_id  input  1  ID instruction is a branch
- link_id  input  1  ID branch is branch-with-link
- flags  output  4  registered PSR {N,Z,C,V}
- carry_in  output  1  registered C, fed to ALU
- cond_true  output  1  condition passes (combinational)
- branch_taken  output  1  take branch this cycle (combinational)
- link_we  output  1  write return address to link register (combinational)
- flush_if  output  1  registered one-cycle squash of the IF instruction

Behaviour:
- Reset (asynchronous, active-high):
  - flags=FLAG_RST, carry_in=FLAG_RST[1].
  - FSM returns to IDLE and flush_if=0.
  - Asserting reset mid-FLUSH aborts the flush immediately.
- Flag update, at posedge clk when s_bit_ex=1 and stall=0: flags<= {alu_n,alu_z,alu_c,alu_v}.
- No flag update when s_bit_ex=0 or stall=1.
- Effective flags for evaluation:
  - s_bit_ex=1: use the live ALU flags (forwarding).
  - s_bit_ex=0: use the registered flags.
  - Forwarding applies even when stall=1.
- Condition table (ARM encoding):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Combinational outputs:
  - cond_true = table(cond_id, effective flags).
  - branch_taken = branch_id & cond_true & !stall & (state==IDLE).
  - link_we = branch_taken & link_id.
- FSM:
  - IDLE: branch_taken=1 -> FLUSH. Otherwise stay in IDLE.
  - FLUSH: flush_if=1 for exactly one cycle. A branch in ID during FLUSH is a squashed wrong-path instruction: it is ignored and branch_taken=0.
  - FLUSH -> IDLE unconditionally when stall=0.
  - stall=1 in FLUSH: remain in FLUSH with flush_if held at 1.
- flush_if is a registered output: it equals (state==FLUSH).
- Simultaneous flag write and branch in the same cycle: the branch uses the forwarded ALU flags. The PSR update completes independently of the branch outcome.
- carry_in always mirrors flags[1]. It is never forwarded, because the ALU consumes it in the same cycle.

Test Plan:
- Reset: assert reset mid-cycle -> flags=0000, flush_if=0 with no clock edge. Release reset, hold stall=0 with no S bit for 5 cycles -> flags remain 0000.
- Flag capture: s_bit_ex=1, ALU flags N=1,Z=0,C=1,V=0 -> flags=1010 after the edge and carry_in=1. Next cycle s_bit_ex=0 with ALU flags 0101 -> flags stays 1010.
- Condition sweep: load flags 0100 (Z=1), sweep cond_id 0..F -> cond_true=1 for EQ,CC,PL,VC,LS,GE,LE,AL and 0 for all others. Repeat with flags 1001 (N=V=1, Z=0) -> GE=1, GT=1, LT=0.
- Forwarding: registered flags 0000, s_bit_ex=1 with alu_z=1, branch_id=1, cond_id=0 (EQ) -> branch_taken=1 in the same cycle. Next cycle flush_if=1, then flush_if=0 the cycle after.
- Branch-with-link and shadow: BL with cond=E -> link_we=1 and branch_taken=1. During the FLUSH cycle present branch_id=1, cond=E -> branch_taken=0, link_we=0.
- Stall: stall=1 with s_bit_ex=1 and a taken-condition branch -> no flag change and branch_taken=0. Stall during FLUSH for 3 cycles -> flush_if stays 1 throughout, then drops one cycle after stall=0.

Source files
------------

// File: rtl/psr_condition_unit.sv
// Program status register and condition evaluation for the ID stage.
// Captures ALU flags on S-bit instructions, resolves branches, and squashes IF after a taken branch.
module psr_condition_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       s_bit_ex,
  input  logic       stall,
  input  logic [3:0] cond_id,
  input  logic       branch_id,
  input  logic       link_id,
  output logic [3:0] flags,
  output logic       carry_in,
  output logic       cond_true,
  output logic       branch_taken,
  output logic       link_we,
  output logic       flush_if
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state_reg;
  logic [3:0] flags_reg;
  logic       flush_reg;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       eff_n, eff_z, eff_c, eff_v;

  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

  // An S-bit instruction in EX forwards its flags to the ID condition check,
  // even while stalled, so the check always sees the newest PSR value.
  assign eff_flags = s_bit_ex ? alu_flags : flags_reg;
  assign eff_n     = eff_flags[3];
  assign eff_z     = eff_flags[2];
  assign eff_c     = eff_flags[1];
  assign eff_v     = eff_flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond_id)
      4'h0: cond_true = eff_z;
      4'h1: cond_true = !eff_z;
      4'h2: cond_true = eff_c;
      4'h3: cond_true = !eff_c;
      4'h4: cond_true = eff_n;
      4'h5: cond_true = !eff_n;
      4'h6: cond_true = eff_v;
      4'h7: cond_true = !eff_v;
      4'h8: cond_true = eff_c && !eff_z;
      4'h9: cond_true = !eff_c || eff_z;
      4'hA: cond_true = (eff_n == eff_v);
      4'hB: cond_true = (eff_n != eff_v);
      4'hC: cond_true = !eff_z && (eff_n == eff_v);
      4'hD: cond_true = eff_z || (eff_n != eff_v);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // The instruction in ID during FLUSH is on the wrong path and must not branch.
  assign branch_taken = branch_id && cond_true && !stall && (state_reg == IDLE);
  assign link_we      = branch_taken && link_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= FLAG_RST;
      state_reg <= IDLE;
      flush_reg <= 1'b0;
    end else if (!stall) begin
      if (s_bit_ex) begin
        flags_reg <= alu_flags;
      end
      case (state_reg)
        IDLE: begin
          if (branch_taken) begin
            state_reg <= FLUSH;
            flush_reg <= 1'b1;
          end
        end
        FLUSH: begin
          state_reg <= IDLE;
          flush_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign flags    = flags_reg;
  assign carry_in = flags_reg[1];
  assign flush_if = flush_reg;

endmodule

// File: tb/tb_psr_condition_unit.sv
// Bench for psr_condition_unit: per-cycle comparison against a behavioural model
// plus directed vectors with hand-computed expectations.
module tb_psr_condition_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic       s_bit_ex = 1'b0, stall = 1'b0;
  logic [3:0] cond_id = 4'h0;
  logic       branch_id = 1'b0, link_id = 1'b0;
  logic [3:0] flags;
  logic       carry_in, cond_true, branch_taken, link_we, flush_if;

  int total_cnt = 0;
  int pass_cnt  = 0;

  psr_condition_unit #(.FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .s_bit_ex(s_bit_ex), .stall(stall),
    .cond_id(cond_id), .branch_id(branch_id), .link_id(link_id),
    .flags(flags), .carry_in(carry_in), .cond_true(cond_true),
    .branch_taken(branch_taken), .link_we(link_we), .flush_if(flush_if)
  );

  always #5 clk = ~clk;

  // Condition rule: odd codes are the negation of the even code below them; NV never passes.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  logic [3:0] m_flags;
  logic       m_flush;
  logic [3:0] m_eff;
  logic       m_ct, m_bt, m_lw;

  always_comb begin
    m_eff = s_bit_ex ? {alu_n, alu_z, alu_c, alu_v} : m_flags;
    m_ct  = model_cond(cond_id, m_eff);
    m_bt  = branch_id & m_ct & ~stall & ~m_flush;
    m_lw  = m_bt & link_id;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags <= 4'b0000;
      m_flush <= 1'b0;
    end else if (!stall) begin
      if (s_bit_ex) m_flags <= {alu_n, alu_z, alu_c, alu_v};
      m_flush <= m_flush ? 1'b0 : m_bt;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  always @(negedge clk) begin
    if ($time > 2) begin
      chk("model_flags",    flags,              m_flags);
      chk("model_carry",    {3'b0, carry_in},   {3'b0, m_flags[1]});
      chk("model_cond",     {3'b0, cond_true},  {3'b0, m_ct});
      chk("model_branch",   {3'b0, branch_taken}, {3'b0, m_bt});
      chk("model_link",     {3'b0, link_we},    {3'b0, m_lw});
      chk("model_flush",    {3'b0, flush_if},   {3'b0, m_flush});
    end
  end

  task automatic set_in(input logic [3:0] alu, input logic s, input logic st,
                        input logic [3:0] c, input logic br, input logic lk);
    {alu_n, alu_z, alu_c, alu_v} = alu;
    s_bit_ex = s; stall = st; cond_id = c; branch_id = br; link_id = lk;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_z, exp_nv;

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_flush", {3'b0, flush_if}, 4'b0);
    repeat (5) tick();
    chk("idle_flags", flags, 4'b0000);

    // Flag capture then hold
    set_in(4'b1010, 1, 0, 4'h0, 0, 0);
    tick();
    chk("cap_flags", flags, 4'b1010);
    chk("cap_carry", {3'b0, carry_in}, 4'b0001);
    set_in(4'b0101, 0, 0, 4'h0, 0, 0);
    tick();
    chk("hold_flags", flags, 4'b1010);

    // Condition sweep with Z=1
    set_in(4'b0100, 1, 0, 4'h0, 0, 0);
    tick();
    set_in(4'b0000, 0, 0, 4'h0, 0, 0);
    exp_z = 16'b0110_0110_1010_1001;
    for (int i = 0; i < 16; i++) begin
      cond_id = i[3:0];
      #1 chk($sformatf("sweepZ_%0d", i), {3'b0, cond_true}, {3'b0, exp_z[i]});
    end
    // Condition sweep with N=V=1
    set_in(4'b1001, 1, 0, 4'h0, 0, 0);
    tick();
    set_in(4'b0000, 0, 0, 4'h0, 0, 0);
    exp_nv = 16'b0101_0110_0101_1010;
    for (int i = 0; i < 16; i++) begin
      cond_id = i[3:0];
      #1 chk($sformatf("sweepNV_%0d", i), {3'b0, cond_true}, {3'b0, exp_nv[i]});
    end
    tick();

    // Forwarding: registered 0000, live Z=1, BEQ
    set_in(4'b0000, 1, 0, 4'h0, 0, 0);
    tick();
    set_in(4'b0100, 1, 0, 4'h0, 1, 0);
    #1 chk("fwd_bt", {3'b0, branch_taken}, 4'b0001);
    chk("fwd_lw", {3'b0, link_we}, 4'b0000);
    tick();
    set_in(4'b0000, 0, 0, 4'h0, 0, 0);
    chk("fwd_flush1", {3'b0, flush_if}, 4'b0001);
    chk("fwd_flags", flags, 4'b0100);
    tick();
    chk("fwd_flush0", {3'b0, flush_if}, 4'b0000);

    // BL, then shadow branch during FLUSH
    set_in(4'b0000, 0, 0, 4'hE, 1, 1);
    #1 chk("bl_lw", {3'b0, link_we}, 4'b0001);
    chk("bl_bt", {3'b0, branch_taken}, 4'b0001);
    tick();
    chk("shadow_flush", {3'b0, flush_if}, 4'b0001);
    chk("shadow_bt", {3'b0, branch_taken}, 4'b0000);
    chk("shadow_lw", {3'b0, link_we}, 4'b0000);
    tick();
    set_in(4'b0000, 0, 0, 4'h0, 0, 0);
    chk("shadow_end", {3'b0, flush_if}, 4'b0000);

    // Stall blocks flag write and branch
    set_in(4'b1111, 1, 1, 4'hE, 1, 0);
    #1 chk("stall_bt", {3'b0, branch_taken}, 4'b0000);
    tick();
    chk("stall_flags", flags, 4'b0100);
    chk("stall_noflush", {3'b0, flush_if}, 4'b0000);
    set_in(4'b0000, 0, 0, 4'hE, 1, 0);
    tick();
    set_in(4'b0000, 0, 1, 4'h0, 0, 0);
    chk("sflush_0", {3'b0, flush_if}, 4'b0001);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("sflush_%0d", i), {3'b0, flush_if}, 4'b0001);
    end
    stall = 1'b0;
    #1 chk("sflush_rel", {3'b0, flush_if}, 4'b0001);
    tick();
    chk("sflush_drop", {3'b0, flush_if}, 4'b0000);

    // Reset mid-FLUSH aborts without a clock edge
    set_in(4'b0000, 0, 0, 4'hE, 1, 0);
    tick();
    set_in(4'b0000, 0, 0, 4'h0, 0, 0);
    chk("pre_rst_flush", {3'b0, flush_if}, 4'b0001);
    #2 reset = 1'b1;
    #1 chk("mid_rst_flush", {3'b0, flush_if}, 4'b0000);
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_carry", {3'b0, carry_in}, 4'b0000);
    tick();
    #2 reset = 1'b0;
    tick();

    // Mixed directed traffic checked by the model each cycle
    set_in(4'b0010, 1, 0, 4'h8, 1, 1);   // HI with C=1,Z=0 forwarded
    tick();
    set_in(4'b1100, 1, 0, 4'hB, 1, 0);   // shadow slot
    tick();
    set_in(4'b0000, 0, 0, 4'hD, 1, 0);   // LE on registered 1100
    tick();
    set_in(4'b0001, 1, 0, 4'hC, 1, 1);   // GT fails: N!=V
    tick();
    set_in(4'b0000, 0, 0, 4'hF, 1, 1);   // NV
    tick();
    chk("end_flags", flags, 4'b0001);
    chk("end_carry", {3'b0, carry_in}, 4'b0000);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
